i2c_cfg_arbiter: RTL and testbench
==================================

Name: i2c_cfg_arbiter

Overview:
Shares one i2c_dri instance between two register-configuration sequencers, e.g. the MS7200 receiver cfg and the MS7210 transmitter cfg, on a single board I2C bus.
- Latches single-cycle exec requests from each requester.
- Grants the bus round-robin and forwards the transaction fields to the driver.
- Routes done, read data and error status back to the requester that issued the transaction.
- Runs a watchdog so a hung transfer cannot lock the bus.
- Clocked by the i2c_dri dri_clk.

Parameters:
- TIMEOUT_CYC, 20'd200_000, maximum cycles from m_exec to m_done before the transfer is aborted as an error.
- GAP_CYC, 8'd4, idle cycles inserted after each transfer before the next grant (minimum 1).

Ports:
- clk, in, 1, I2C operation clock (i2c_dri dri_clk).
- rst, in, 1, asynchronous active-high reset.
- rN_exec, in, 1, N=0,1: single-cycle transaction request.
- rN_slave_addr, in, 7, N=0,1: 7-bit device address.
- rN_bit_ctrl, in, 1, N=0,1: 0 = 8-bit register address, 1 = 16-bit register address.
- rN_rh_wl, in, 1, N=0,1: 1 = read, 0 = write.
- rN_addr, in, 16, N=0,1: register address.
- rN_data_w, in, 8, N=0,1: write data.
- rN_done, out, 1, N=0,1: single-cycle completion pulse.
- rN_err, out, 1, N=0,1: valid with rN_done; 1 = NACK or timeout.
- rN_data_r, out, 8, N=0,1: read data, held until that requester's next completion.
- m_exec, out, 1, exec strobe to i2c_dri.
- m_slave_addr, out, 7, to driver.
- m_bit_ctrl, out, 1, to driver.
- m_rh_wl, out, 1, to driver.
- m_addr, out, 16, to driver.
- m_data_w, out, 8, to driver.
- m_done, in, 1, driver completion pulse.
- m_ack, in, 1, driver ack flag, sampled with m_done; 1 = NACK.
- m_data_r, in, 8, driver read data, valid with m_done.
- busy, out, 1, high in every state except IDLE.
- grant, out, 1, index of the current or last-served requester.

Behaviour:
- Reset state:
  - All outputs 0 and pend0/pend1 = 0.
  - grant = 1, so requester 0 wins the first contention.
  - State = IDLE and counters = 0.
  - Reset is asynchronous and aborts any transfer in flight; no done pulse is produced for it.
- Pending latch:
  - rN_exec high at an edge sets pendN.
  - pendN clears on the edge that leaves IDLE with N granted.
  - An exec while pendN is already 1 is ignored.
  - An exec from the requester currently being served sets pendN, so a new job queues behind it.
- FSM:
  - IDLE:
    - If neither request is pending, stay in IDLE.
    - If exactly one is pending, grant it.
    - If both are pending, grant the requester != grant (round-robin).
    - On grant: capture that requester's slave_addr, bit_ctrl, rh_wl, addr and data_w into the m_* registers, update grant, go to ISSUE.
  - ISSUE:
    - m_exec = 1 for exactly this one cycle.
    - Watchdog counter cleared.
    - Go to BUSY.
  - BUSY:
    - Counter increments each cycle.
    - On m_done: rN_data_r <= m_data_r (reads only; writes leave it unchanged), rN_err <= m_ack, rN_done pulses one cycle, go to GAP.
    - If the counter reaches TIMEOUT_CYC-1 without m_done: rN_done = 1 and rN_err = 1, go to GAP.
    - m_done in the same cycle as the timeout: the done path wins.
  - GAP:
    - Stay GAP_CYC cycles, then go to IDLE.
- Latency:
  - rN_exec pulse at cycle 0 with the arbiter idle → pend at cycle 1 → m_exec high in cycle 2.
  - rN_done is high in the cycle after m_done.
- Registers and stability:
  - All outputs are registered.
  - m_* fields stay stable from ISSUE until the next grant.
  - rN_err is updated only on completion.
- Ignored inputs:
  - m_done outside BUSY is ignored.
  - The other requester's done/err/data_r never change during a transfer.

Test Plan:
1. Write path: r0_exec with addr 16'h1234, data 8'hA5, slave 7'h2B → m_exec in cycle 2 with m_addr = 16'h1234, m_data_w = 8'hA5; m_done with m_ack = 0 → r0_done = 1, r0_err = 0 next cycle; r1_done stays 0.
2. Contention after reset: r0_exec and r1_exec in the same cycle → r0 served first; then GAP_CYC idle cycles; then r1 issued; grant goes 0 then 1.
3. Round-robin: r0 and r1 re-request continuously → issue order 0, 1, 0, 1; neither requester is served twice in a row while the other is pending.
4. Read routing: r1 read with m_data_r = 8'h5C → r1_data_r = 8'h5C and r0_data_r unchanged; r1 NACK (m_ack = 1) → r1_err = 1.
5. Timeout: TIMEOUT_CYC = 16, m_done never asserted → r0_done = 1 and r0_err = 1 in the 16th BUSY cycle; the arbiter then serves pending r1.
6. Reset mid-BUSY: assert rst → busy = 0 and m_exec = 0 immediately, pend cleared, no rN_done; after reset release a new r1_exec is served normally.

Source files
------------

// File: rtl/i2c_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_cfg_arbiter
//
// Shares one i2c_dri instance between two register-configuration sequencers
// (for example the MS7200 receiver cfg and the MS7210 transmitter cfg) on one
// board I2C bus. Each requester's single-cycle exec pulse is latched as a
// pending request. The bus is granted round-robin, and the granted requester's
// transaction fields are forwarded to the driver. Completion, read data and
// error status are routed back to the requester that owns the transfer. A
// watchdog aborts a transfer that never completes. Runs on dri_clk.
//
// Parameters
//   TIMEOUT_CYC  cycles from m_exec to m_done before the transfer is aborted
//   GAP_CYC      idle cycles after each transfer before the next grant (>= 1)
//
// Ports
//   clk, rst                  dri_clk, asynchronous active-high reset
//   rN_exec                   single-cycle request from requester N (N = 0, 1)
//   rN_slave_addr/bit_ctrl/   transaction fields from requester N
//   rN_rh_wl/addr/data_w
//   rN_done, rN_err           one-cycle completion pulse; error flag valid with it
//   rN_data_r                 read data, held until N's next completion
//   m_exec, m_slave_addr,     strobe and transaction fields to i2c_dri
//   m_bit_ctrl, m_rh_wl,
//   m_addr, m_data_w
//   m_done, m_ack, m_data_r   completion, NACK flag and read data from i2c_dri
//   busy                      high whenever the arbiter is not IDLE
//   grant                     index of the current or last-served requester
// -----------------------------------------------------------------------------
module i2c_cfg_arbiter #(
  parameter logic [19:0] TIMEOUT_CYC = 20'd200_000,
  parameter logic [7:0]  GAP_CYC     = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  // requester 0
  input  logic        r0_exec,
  input  logic [6:0]  r0_slave_addr,
  input  logic        r0_bit_ctrl,
  input  logic        r0_rh_wl,
  input  logic [15:0] r0_addr,
  input  logic [7:0]  r0_data_w,
  output logic        r0_done,
  output logic        r0_err,
  output logic [7:0]  r0_data_r,
  // requester 1
  input  logic        r1_exec,
  input  logic [6:0]  r1_slave_addr,
  input  logic        r1_bit_ctrl,
  input  logic        r1_rh_wl,
  input  logic [15:0] r1_addr,
  input  logic [7:0]  r1_data_w,
  output logic        r1_done,
  output logic        r1_err,
  output logic [7:0]  r1_data_r,
  // i2c_dri side
  output logic        m_exec,
  output logic [6:0]  m_slave_addr,
  output logic        m_bit_ctrl,
  output logic        m_rh_wl,
  output logic [15:0] m_addr,
  output logic [7:0]  m_data_w,
  input  logic        m_done,
  input  logic        m_ack,
  input  logic [7:0]  m_data_r,
  // status
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_GAP
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        pend0_q, pend0_d;
  logic        pend1_q, pend1_d;
  logic        grant_q, grant_d;
  logic        busy_q, busy_d;

  logic        m_exec_q, m_exec_d;
  logic [6:0]  m_slave_addr_q, m_slave_addr_d;
  logic        m_bit_ctrl_q, m_bit_ctrl_d;
  logic        m_rh_wl_q, m_rh_wl_d;
  logic [15:0] m_addr_q, m_addr_d;
  logic [7:0]  m_data_w_q, m_data_w_d;

  logic        r0_done_q, r0_done_d;
  logic        r0_err_q, r0_err_d;
  logic [7:0]  r0_data_r_q, r0_data_r_d;
  logic        r1_done_q, r1_done_d;
  logic        r1_err_q, r1_err_d;
  logic [7:0]  r1_data_r_q, r1_data_r_d;

  logic        take;  // a grant happens on this edge
  logic        sel;   // requester chosen when take is high

  // Shared counter: watchdog while a transfer is outstanding, gap timer after it.
  localparam logic [19:0] TIMEOUT_LAST = TIMEOUT_CYC - 20'd1;
  localparam logic [19:0] GAP_LAST     = {12'd0, GAP_CYC} - 20'd1;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    grant_d        = grant_q;
    m_exec_d       = 1'b0;
    m_slave_addr_d = m_slave_addr_q;
    m_bit_ctrl_d   = m_bit_ctrl_q;
    m_rh_wl_d      = m_rh_wl_q;
    m_addr_d       = m_addr_q;
    m_data_w_d     = m_data_w_q;
    r0_done_d      = 1'b0;
    r0_err_d       = r0_err_q;
    r0_data_r_d    = r0_data_r_q;
    r1_done_d      = 1'b0;
    r1_err_d       = r1_err_q;
    r1_data_r_d    = r1_data_r_q;
    take           = 1'b0;
    sel            = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = 20'd0;
        if (pend0_q || pend1_q) begin
          take = 1'b1;
          // Round-robin on contention: the requester not served last time wins.
          sel  = (pend0_q && pend1_q) ? ~grant_q : pend1_q;
          grant_d  = sel;
          m_exec_d = 1'b1;
          state_d  = S_ISSUE;
          if (sel) begin
            m_slave_addr_d = r1_slave_addr;
            m_bit_ctrl_d   = r1_bit_ctrl;
            m_rh_wl_d      = r1_rh_wl;
            m_addr_d       = r1_addr;
            m_data_w_d     = r1_data_w;
          end else begin
            m_slave_addr_d = r0_slave_addr;
            m_bit_ctrl_d   = r0_bit_ctrl;
            m_rh_wl_d      = r0_rh_wl;
            m_addr_d       = r0_addr;
            m_data_w_d     = r0_data_w;
          end
        end
      end

      S_ISSUE: begin
        // The watchdog starts from zero here; the exec cycle counts as cycle 0
        // of the TIMEOUT_CYC window.
        cnt_d   = 20'd1;
        state_d = S_BUSY;
      end

      S_BUSY: begin
        cnt_d = cnt_q + 20'd1;
        // m_done is tested first so a completion coinciding with the timeout
        // still reports the driver's real status.
        if (m_done) begin
          state_d = S_GAP;
          cnt_d   = 20'd0;
          if (grant_q) begin
            r1_done_d = 1'b1;
            r1_err_d  = m_ack;
            if (m_rh_wl_q) r1_data_r_d = m_data_r;
          end else begin
            r0_done_d = 1'b1;
            r0_err_d  = m_ack;
            if (m_rh_wl_q) r0_data_r_d = m_data_r;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_GAP;
          cnt_d   = 20'd0;
          if (grant_q) begin
            r1_done_d = 1'b1;
            r1_err_d  = 1'b1;
          end else begin
            r0_done_d = 1'b1;
            r0_err_d  = 1'b1;
          end
        end
      end

      S_GAP: begin
        cnt_d = cnt_q + 20'd1;
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 20'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 20'd0;
      end
    endcase
  end

  // A set pending flag ignores further execs and only clears when granted; a
  // clear flag is set by any exec, including one from the requester in service.
  assign pend0_d = pend0_q ? ~(take && !sel) : r0_exec;
  assign pend1_d = pend1_q ? ~(take &&  sel) : r1_exec;
  assign busy_d  = (state_d != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 20'd0;
      pend0_q        <= 1'b0;
      pend1_q        <= 1'b0;
      grant_q        <= 1'b1;  // requester 0 wins the first contention
      busy_q         <= 1'b0;
      m_exec_q       <= 1'b0;
      m_slave_addr_q <= 7'd0;
      m_bit_ctrl_q   <= 1'b0;
      m_rh_wl_q      <= 1'b0;
      m_addr_q       <= 16'd0;
      m_data_w_q     <= 8'd0;
      r0_done_q      <= 1'b0;
      r0_err_q       <= 1'b0;
      r0_data_r_q    <= 8'd0;
      r1_done_q      <= 1'b0;
      r1_err_q       <= 1'b0;
      r1_data_r_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend0_q        <= pend0_d;
      pend1_q        <= pend1_d;
      grant_q        <= grant_d;
      busy_q         <= busy_d;
      m_exec_q       <= m_exec_d;
      m_slave_addr_q <= m_slave_addr_d;
      m_bit_ctrl_q   <= m_bit_ctrl_d;
      m_rh_wl_q      <= m_rh_wl_d;
      m_addr_q       <= m_addr_d;
      m_data_w_q     <= m_data_w_d;
      r0_done_q      <= r0_done_d;
      r0_err_q       <= r0_err_d;
      r0_data_r_q    <= r0_data_r_d;
      r1_done_q      <= r1_done_d;
      r1_err_q       <= r1_err_d;
      r1_data_r_q    <= r1_data_r_d;
    end
  end

  assign m_exec       = m_exec_q;
  assign m_slave_addr = m_slave_addr_q;
  assign m_bit_ctrl   = m_bit_ctrl_q;
  assign m_rh_wl      = m_rh_wl_q;
  assign m_addr       = m_addr_q;
  assign m_data_w     = m_data_w_q;
  assign r0_done      = r0_done_q;
  assign r0_err       = r0_err_q;
  assign r0_data_r    = r0_data_r_q;
  assign r1_done      = r1_done_q;
  assign r1_err       = r1_err_q;
  assign r1_data_r    = r1_data_r_q;
  assign busy         = busy_q;
  assign grant        = grant_q;

endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_cfg_arbiter
//
// Directed bench for i2c_cfg_arbiter with TIMEOUT_CYC = 16 and GAP_CYC = 4.
// The bench plays the i2c_dri role itself. Inputs are driven, and outputs
// sampled, 1 ns after each rising edge. "Cycle 0" is the cycle in which an exec
// is driven.
// -----------------------------------------------------------------------------
module tb_i2c_cfg_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_exec, r1_exec;
  logic [6:0]  r0_slave_addr, r1_slave_addr;
  logic        r0_bit_ctrl, r1_bit_ctrl;
  logic        r0_rh_wl, r1_rh_wl;
  logic [15:0] r0_addr, r1_addr;
  logic [7:0]  r0_data_w, r1_data_w;
  logic        r0_done, r1_done;
  logic        r0_err, r1_err;
  logic [7:0]  r0_data_r, r1_data_r;
  logic        m_exec;
  logic [6:0]  m_slave_addr;
  logic        m_bit_ctrl;
  logic        m_rh_wl;
  logic [15:0] m_addr;
  logic [7:0]  m_data_w;
  logic        m_done;
  logic        m_ack;
  logic [7:0]  m_data_r;
  logic        busy;
  logic        grant;

  int n_pass  = 0;
  int n_total = 0;

  i2c_cfg_arbiter #(
    .TIMEOUT_CYC(20'd16),
    .GAP_CYC    (8'd4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .r0_exec      (r0_exec),
    .r0_slave_addr(r0_slave_addr),
    .r0_bit_ctrl  (r0_bit_ctrl),
    .r0_rh_wl     (r0_rh_wl),
    .r0_addr      (r0_addr),
    .r0_data_w    (r0_data_w),
    .r0_done      (r0_done),
    .r0_err       (r0_err),
    .r0_data_r    (r0_data_r),
    .r1_exec      (r1_exec),
    .r1_slave_addr(r1_slave_addr),
    .r1_bit_ctrl  (r1_bit_ctrl),
    .r1_rh_wl     (r1_rh_wl),
    .r1_addr      (r1_addr),
    .r1_data_w    (r1_data_w),
    .r1_done      (r1_done),
    .r1_err       (r1_err),
    .r1_data_r    (r1_data_r),
    .m_exec       (m_exec),
    .m_slave_addr (m_slave_addr),
    .m_bit_ctrl   (m_bit_ctrl),
    .m_rh_wl      (m_rh_wl),
    .m_addr       (m_addr),
    .m_data_w     (m_data_w),
    .m_done       (m_done),
    .m_ack        (m_ack),
    .m_data_r     (m_data_r),
    .busy         (busy),
    .grant        (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "bench watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for m_exec, check the grant, complete the transfer in the
  // first BUSY cycle and check the completion of the expected requester.
  task automatic serve(input string tag, input logic exp_g, input logic ack,
                       input logic [7:0] rd);
    int waited = 0;
    while (m_exec !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    check({tag, "_issued"}, {31'd0, m_exec}, 32'd1);
    check({tag, "_grant"}, {31'd0, grant}, {31'd0, exp_g});
    tick();
    m_done   = 1'b1;
    m_ack    = ack;
    m_data_r = rd;
    tick();
    m_done   = 1'b0;
    m_ack    = 1'b0;
    m_data_r = 8'h00;
    check({tag, "_done"}, {31'd0, (exp_g ? r1_done : r0_done)}, 32'd1);
    check({tag, "_other_done"}, {31'd0, (exp_g ? r0_done : r1_done)}, 32'd0);
    check({tag, "_err"}, {31'd0, (exp_g ? r1_err : r0_err)}, {31'd0, ack});
  endtask

  initial begin
    logic stray;

    rst = 1'b1;
    r0_exec = 1'b0; r1_exec = 1'b0;
    r0_slave_addr = 7'd0; r1_slave_addr = 7'd0;
    r0_bit_ctrl = 1'b0; r1_bit_ctrl = 1'b0;
    r0_rh_wl = 1'b0; r1_rh_wl = 1'b0;
    r0_addr = 16'd0; r1_addr = 16'd0;
    r0_data_w = 8'd0; r1_data_w = 8'd0;
    m_done = 1'b0; m_ack = 1'b0; m_data_r = 8'd0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {31'd0, grant}, 32'd1);
    check("rst_m_exec", {31'd0, m_exec}, 32'd0);
    check("rst_dones", {30'd0, r1_done, r0_done}, 32'd0);
    check("rst_m_addr", {16'd0, m_addr}, 32'd0);
    rst = 1'b0;

    // ---------------- 1: write path ----------------
    r0_slave_addr = 7'h2B; r0_addr = 16'h1234; r0_data_w = 8'hA5;
    r0_bit_ctrl = 1'b1; r0_rh_wl = 1'b0;
    r0_exec = 1'b1;                                   // cycle 0
    tick(); r0_exec = 1'b0;                           // cycle 1
    check("wr_c1_m_exec", {31'd0, m_exec}, 32'd0);
    check("wr_c1_busy", {31'd0, busy}, 32'd0);
    tick();                                           // cycle 2: ISSUE
    check("wr_c2_m_exec", {31'd0, m_exec}, 32'd1);
    check("wr_m_addr", {16'd0, m_addr}, 32'h1234);
    check("wr_m_data_w", {24'd0, m_data_w}, 32'hA5);
    check("wr_m_slave", {25'd0, m_slave_addr}, 32'h2B);
    check("wr_m_bit_ctrl", {31'd0, m_bit_ctrl}, 32'd1);
    check("wr_grant", {31'd0, grant}, 32'd0);
    check("wr_busy", {31'd0, busy}, 32'd1);
    tick();                                           // cycle 3: BUSY
    check("wr_c3_m_exec", {31'd0, m_exec}, 32'd0);
    m_done = 1'b1; m_ack = 1'b0;
    tick(); m_done = 1'b0;                            // cycle 4
    check("wr_r0_done", {31'd0, r0_done}, 32'd1);
    check("wr_r0_err", {31'd0, r0_err}, 32'd0);
    check("wr_r1_done", {31'd0, r1_done}, 32'd0);
    tick();                                           // cycle 5
    check("wr_r0_done_pulse", {31'd0, r0_done}, 32'd0);
    check("wr_m_addr_stable", {16'd0, m_addr}, 32'h1234);
    tick(); tick(); tick();                           // cycle 8: IDLE
    check("wr_idle_busy", {31'd0, busy}, 32'd0);
    // m_done outside BUSY is ignored
    m_done = 1'b1; m_ack = 1'b1;
    tick(); m_done = 1'b0; m_ack = 1'b0;
    tick();
    check("stray_done", {30'd0, r1_done, r0_done}, 32'd0);
    check("stray_err", {31'd0, r0_err}, 32'd0);
    check("stray_busy", {31'd0, busy}, 32'd0);

    // ---------------- 2: contention after reset ----------------
    apply_reset();
    r0_slave_addr = 7'h11; r1_slave_addr = 7'h22;
    r0_exec = 1'b1; r1_exec = 1'b1;                   // cycle 0
    tick(); r0_exec = 1'b0; r1_exec = 1'b0;           // cycle 1
    tick();                                           // cycle 2
    check("ct_first_exec", {31'd0, m_exec}, 32'd1);
    check("ct_first_grant", {31'd0, grant}, 32'd0);
    check("ct_first_slave", {25'd0, m_slave_addr}, 32'h11);
    tick(); m_done = 1'b1;                            // cycle 3
    tick(); m_done = 1'b0;                            // cycle 4
    check("ct_r0_done", {31'd0, r0_done}, 32'd1);
    for (int c = 4; c <= 8; c++) begin
      check($sformatf("ct_gap_c%0d", c), {31'd0, m_exec}, 32'd0);
      tick();
    end                                               // cycle 9
    check("ct_second_exec", {31'd0, m_exec}, 32'd1);
    check("ct_second_grant", {31'd0, grant}, 32'd1);
    check("ct_second_slave", {25'd0, m_slave_addr}, 32'h22);

    // ---------------- 3: round-robin, both re-request continuously ----------------
    r0_exec = 1'b1; r1_exec = 1'b1;
    tick(); m_done = 1'b1;                            // cycle 10: BUSY
    tick(); m_done = 1'b0;                            // cycle 11
    check("rr_r1_done", {31'd0, r1_done}, 32'd1);
    check("rr_r0_quiet", {31'd0, r0_done}, 32'd0);
    serve("rr_a", 1'b0, 1'b0, 8'h00);
    serve("rr_b", 1'b1, 1'b0, 8'h00);
    serve("rr_c", 1'b0, 1'b0, 8'h00);
    serve("rr_d", 1'b1, 1'b0, 8'h00);
    r0_exec = 1'b0; r1_exec = 1'b0;

    // ---------------- 4: read routing ----------------
    apply_reset();
    r0_rh_wl = 1'b1; r0_exec = 1'b1;
    tick(); r0_exec = 1'b0;
    serve("rd0", 1'b0, 1'b0, 8'h3C);
    check("rd0_data", {24'd0, r0_data_r}, 32'h3C);
    check("rd0_r1_data", {24'd0, r1_data_r}, 32'h00);
    r1_rh_wl = 1'b1; r1_exec = 1'b1;
    tick(); r1_exec = 1'b0;
    serve("rd1", 1'b1, 1'b1, 8'h5C);
    check("rd1_data", {24'd0, r1_data_r}, 32'h5C);
    check("rd1_err", {31'd0, r1_err}, 32'd1);
    check("rd1_r0_data", {24'd0, r0_data_r}, 32'h3C);
    check("rd1_r0_err", {31'd0, r0_err}, 32'd0);
    r0_rh_wl = 1'b0; r0_exec = 1'b1;                  // write must not touch data_r
    tick(); r0_exec = 1'b0;
    serve("wr0", 1'b0, 1'b0, 8'hFF);
    check("wr0_data_kept", {24'd0, r0_data_r}, 32'h3C);
    check("wr0_r1_err_kept", {31'd0, r1_err}, 32'd1);

    // ---------------- 5: timeout ----------------
    apply_reset();
    r1_rh_wl = 1'b0;
    r0_exec = 1'b1; r1_exec = 1'b1;                   // cycle 0
    tick(); r0_exec = 1'b0; r1_exec = 1'b0;
    tick();                                           // X = exec cycle
    check("to_exec", {31'd0, m_exec}, 32'd1);
    check("to_grant", {31'd0, grant}, 32'd0);
    repeat (15) tick();                               // X+15: last BUSY cycle
    check("to_not_yet", {31'd0, r0_done}, 32'd0);
    check("to_still_busy", {31'd0, busy}, 32'd1);
    tick();                                           // X+16
    check("to_done", {31'd0, r0_done}, 32'd1);
    check("to_err", {31'd0, r0_err}, 32'd1);
    check("to_r1_quiet", {31'd0, r1_done}, 32'd0);
    repeat (4) tick();                                // X+20: IDLE
    check("to_gap_no_exec", {31'd0, m_exec}, 32'd0);
    tick();                                           // X+21
    check("to_r1_exec", {31'd0, m_exec}, 32'd1);
    check("to_r1_grant", {31'd0, grant}, 32'd1);

    // ---------------- 6: reset mid-BUSY ----------------
    tick();                                           // BUSY for r1
    r0_exec = 1'b1;
    tick(); r0_exec = 1'b0;                           // pend0 now set
    #3 rst = 1'b1;
    #1;
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_m_exec", {31'd0, m_exec}, 32'd0);
    check("mr_grant", {31'd0, grant}, 32'd1);
    tick(); tick();
    rst = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_exec !== 1'b0 || r0_done !== 1'b0 || r1_done !== 1'b0) stray = 1'b1;
      tick();
    end
    check("mr_no_activity", {31'd0, stray}, 32'd0);
    r1_exec = 1'b1;                                   // cycle 0
    tick(); r1_exec = 1'b0;
    tick();                                           // cycle 2
    check("mr_new_exec", {31'd0, m_exec}, 32'd1);
    serve("mr_new", 1'b1, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
